// File: rtl/sample_frame_ctrl.sv
// rtl/sample_frame_ctrl.sv - frame sequencer: gates sample strobes into the buffer,
// counts a frame and hands it to the processing engine with a watchdog.
module sample_frame_ctrl #(
  parameter int NUM_CNT_BITS   = 10,
  parameter int FRAME_LEN      = 1000,
  parameter int TIMEOUT_BITS   = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    continuous,
  input  logic                    sample_strobe,
  output logic                    sample_accept,
  output logic [NUM_CNT_BITS-1:0] sample_addr,
  output logic                    one_k_samples,
  output logic                    proc_start,
  input  logic                    proc_done,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQUIRE,
    S_START_PROC,
    S_WAIT_PROC
  } state_e;

  localparam logic [NUM_CNT_BITS-1:0] CNT_LAST   = NUM_CNT_BITS'(FRAME_LEN - 1);
  localparam logic [TIMEOUT_BITS-1:0] TIMER_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic [TIMEOUT_BITS-1:0] timer_q, timer_d;
  logic                    overrun_q, overrun_d;
  logic                    timeout_err_q, timeout_err_d;
  logic                    accept_c;
  logic                    frame_full_c;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    timer_d       = timer_q;
    overrun_d     = overrun_q;
    timeout_err_d = timeout_err_q;
    accept_c      = 1'b0;
    frame_full_c  = 1'b0;

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d       = S_ACQUIRE;
            count_d       = '0;
            overrun_d     = 1'b0;
            timeout_err_d = 1'b0;
          end
        end
        S_ACQUIRE: begin
          if (sample_strobe) begin
            accept_c = 1'b1;
            if (count_q == CNT_LAST) begin
              count_d = '0;
              state_d = S_START_PROC;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        S_START_PROC: begin
          frame_full_c = 1'b1;
          timer_d      = '0;
          state_d      = S_WAIT_PROC;
        end
        S_WAIT_PROC: begin
          // proc_done beats expiry when both land in the same cycle
          if (proc_done) begin
            state_d = continuous ? S_ACQUIRE : S_IDLE;
          end else if (timer_q == TIMER_LAST) begin
            timeout_err_d = 1'b1;
            state_d       = S_IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (sample_strobe && ((state_q == S_START_PROC) || (state_q == S_WAIT_PROC))) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      timer_q       <= '0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign sample_accept = accept_c & ~rst;
  assign sample_addr   = count_q;
  assign one_k_samples = frame_full_c;
  assign proc_start    = frame_full_c;
  assign busy          = (state_q != S_IDLE);
  assign overrun       = overrun_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_sample_frame_ctrl.sv
// tb/tb_sample_frame_ctrl.sv - scoreboard bench for sample_frame_ctrl
module tb_sample_frame_ctrl;

  localparam int NB   = 10;
  localparam int FLEN = 1000;
  localparam int TB   = 16;
  localparam int TCYC = 20;

  logic          clk = 1'b0;
  logic          rst, start, abort, continuous, sample_strobe, proc_done;
  logic          sample_accept, one_k_samples, proc_start, busy, overrun, timeout_err;
  logic [NB-1:0] sample_addr;

  int total = 0;
  int bad   = 0;
  int n_pstart = 0;
  int exp_cnt = 0;
  bit cont_window = 1'b0;
  bit busy_dropped = 1'b0;
  int exp_q[$];

  sample_frame_ctrl #(
    .NUM_CNT_BITS(NB), .FRAME_LEN(FLEN), .TIMEOUT_BITS(TB), .TIMEOUT_CYCLES(TCYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .continuous(continuous),
    .sample_strobe(sample_strobe), .sample_accept(sample_accept), .sample_addr(sample_addr),
    .one_k_samples(one_k_samples), .proc_start(proc_start), .proc_done(proc_done),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // mid-cycle monitor: scoreboard for accepted addresses, pulse bookkeeping
  always @(negedge clk) begin
    if (sample_accept === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_accept: got addr %0d want no accept", sample_addr);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (sample_addr !== NB'(e)) begin
          bad++;
          $display("FAIL accept_addr: got %0d want %0d", sample_addr, e);
        end
      end
    end
    if (proc_start === 1'b1 || one_k_samples === 1'b1) begin
      n_pstart++;
      total++;
      if (one_k_samples !== proc_start) begin
        bad++;
        $display("FAIL pulse_pair: got one_k=%0b proc_start=%0b want equal", one_k_samples, proc_start);
      end
    end
    if (cont_window && busy !== 1'b1) busy_dropped = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_cnt = 0;
  endtask

  // n strobes, gap idle cycles after each but the last; acc says whether they should be accepted
  task automatic feed(input int n, input int gap, input bit acc);
    for (int i = 0; i < n; i++) begin
      sample_strobe = 1'b1;
      if (acc) begin
        exp_q.push_back(exp_cnt);
        exp_cnt = (exp_cnt == FLEN - 1) ? 0 : exp_cnt + 1;
      end
      tick();
      sample_strobe = 1'b0;
      if (i < n - 1) repeat (gap) tick();
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_accepts: got %0d pending want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    sample_strobe = 1'b0; proc_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({busy, overrun, timeout_err, proc_start, one_k_samples, sample_accept} !== 6'b0 || sample_addr !== '0) begin
      bad++;
      $display("FAIL reset_state: got busy=%0b ovr=%0b terr=%0b addr=%0d want all 0", busy, overrun, timeout_err, sample_addr);
    end
    do_start();
    feed(37, 0, 1'b1);
    total++;
    if (sample_addr !== NB'(37)) begin
      bad++;
      $display("FAIL mid_frame_count: got %0d want 37", sample_addr);
    end
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || sample_addr !== '0 || overrun !== 1'b0 || timeout_err !== 1'b0 || proc_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_acquire: got busy=%0b addr=%0d ovr=%0b terr=%0b ps=%0b want 0", busy, sample_addr, overrun, timeout_err, proc_start);
    end
    check_drained("reset");
  endtask

  task automatic test_full_frame();
    int p0;
    p0 = n_pstart;
    continuous = 1'b0;
    do_start();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %0b want 1", busy); end
    feed(FLEN, 2, 1'b1);
    total++;
    if (proc_start !== 1'b1 || one_k_samples !== 1'b1) begin
      bad++;
      $display("FAIL frame_full_pulse: got ps=%0b ok=%0b want 1", proc_start, one_k_samples);
    end
    tick();
    total++;
    if (proc_start !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pulse_width: got ps=%0b busy=%0b want 0,1", proc_start, busy);
    end
    repeat (3) tick();
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL done_to_idle: got busy=%0b want 0", busy); end
    total++;
    if (n_pstart - p0 != 1) begin bad++; $display("FAIL full_frame_pulses: got %0d want 1", n_pstart - p0); end
    check_drained("full_frame");
  endtask

  task automatic test_continuous();
    int p0;
    p0 = n_pstart;
    continuous = 1'b1;
    do_start();
    cont_window = 1'b1;
    busy_dropped = 1'b0;
    for (int f = 0; f < 2; f++) begin
      feed(FLEN, 0, 1'b1);
      tick();
      tick();
      if (f == 1) continuous = 1'b0;
      proc_done = 1'b1;
      tick();
      proc_done = 1'b0;
      if (f == 1) cont_window = 1'b0;
    end
    total++;
    if (busy_dropped) begin bad++; $display("FAIL cont_busy: got busy dropped want steady 1"); end
    total++;
    if (n_pstart - p0 != 2) begin bad++; $display("FAIL cont_pulses: got %0d want 2", n_pstart - p0); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL cont_exit_idle: got busy=%0b want 0", busy); end
    check_drained("continuous");
  endtask

  task automatic test_overrun();
    continuous = 1'b0;
    do_start();
    feed(FLEN, 0, 1'b1);
    tick();
    feed(3, 1, 1'b0);
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %0b want 1", overrun); end
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    tick(); tick();
    total++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL overrun_sticky: got ovr=%0b busy=%0b want 1,0", overrun, busy);
    end
    feed(2, 0, 1'b0);
    do_start();
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %0b want 0", overrun); end
    abort = 1'b1; tick(); abort = 1'b0;
    check_drained("overrun");
  endtask

  task automatic test_timeout();
    continuous = 1'b0;
    do_start();
    feed(FLEN, 0, 1'b1);
    tick();
    repeat (TCYC - 1) tick();
    total++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early: got busy=%0b terr=%0b want 1,0", busy, timeout_err);
    end
    tick();
    total++;
    if (busy !== 1'b0 || timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_fire: got busy=%0b terr=%0b want 0,1", busy, timeout_err);
    end
    do_start();
    total++;
    if (timeout_err !== 1'b0) begin bad++; $display("FAIL terr_clear: got %0b want 0", timeout_err); end
    feed(FLEN, 0, 1'b1);
    tick();
    repeat (TCYC - 1) tick();
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    total++;
    if (busy !== 1'b0 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL done_beats_timeout: got busy=%0b terr=%0b want 0,0", busy, timeout_err);
    end
    check_drained("timeout");
  endtask

  task automatic test_abort();
    continuous = 1'b0;
    do_start();
    feed(500, 0, 1'b1);
    sample_strobe = 1'b1;
    abort = 1'b1;
    #1;
    total++;
    if (sample_accept !== 1'b0) begin bad++; $display("FAIL abort_accept: got %0b want 0", sample_accept); end
    tick();
    sample_strobe = 1'b0;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || sample_addr !== '0) begin
      bad++;
      $display("FAIL abort_idle: got busy=%0b addr=%0d want 0,0", busy, sample_addr);
    end
    do_start();
    feed(1, 0, 1'b1);
    feed(FLEN - 1, 0, 1'b1);
    abort = 1'b1;
    #1;
    total++;
    if (proc_start !== 1'b0 || one_k_samples !== 1'b0) begin
      bad++;
      $display("FAIL abort_start_proc: got ps=%0b ok=%0b want 0,0", proc_start, one_k_samples);
    end
    tick();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_sp_idle: got busy=%0b want 0", busy); end
    check_drained("abort");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_continuous();
    test_overrun();
    test_timeout();
    test_abort();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
